// File: rtl/nvdla_stream_arbiter.sv
// nvdla_stream_arbiter
//   Merges N_CH valid/ready data streams onto one registered output stream.
//   Arbitration is round-robin (mode_i=0) or fixed priority, lowest index
//   first (mode_i=1). A grant is held for up to MAX_BURST beats, or until
//   the granted source drops valid.
//
// Ports
//   clk_i        rising-edge clock
//   rst_i        synchronous active-high reset
//   enable_i     0: no new grant, granted input frozen
//   clear_i      synchronous soft clear, same effect as rst_i
//   mode_i       0 = round-robin, 1 = fixed priority
//   in_valid_i   per-channel valid            [N_CH]
//   in_data_i    per-channel data, ch0 in LSBs [N_CH*DW]
//   in_ready_o   per-channel ready            [N_CH]
//   out_valid_o  registered output valid
//   out_data_o   registered output data       [DW]
//   out_ch_o     source channel of output beat
//   out_ready_i  downstream ready
//   busy_o       a grant is held (LOCK)
module nvdla_stream_arbiter #(
  parameter int unsigned N_CH      = 3,
  parameter int unsigned DW        = 32,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    enable_i,
  input  logic                    clear_i,
  input  logic                    mode_i,
  input  logic [N_CH-1:0]         in_valid_i,
  input  logic [N_CH*DW-1:0]      in_data_i,
  output logic [N_CH-1:0]         in_ready_o,
  output logic                    out_valid_o,
  output logic [DW-1:0]           out_data_o,
  output logic [$clog2(N_CH)-1:0] out_ch_o,
  input  logic                    out_ready_i,
  output logic                    busy_o
);

  localparam int unsigned   CW        = $clog2(N_CH);
  localparam int unsigned   BW        = $clog2(MAX_BURST + 1);
  localparam logic [CW:0]   N_CH_W    = (CW+1)'(N_CH);
  localparam logic [CW-1:0] LAST_CH   = CW'(N_CH - 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BURST - 1);

  typedef enum logic {
    IDLE,
    LOCK
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] grant_q, grant_d;
  logic [CW-1:0] rr_q, rr_d;
  logic [BW-1:0] beat_q, beat_d;
  logic          ov_q, ov_d;
  logic [DW-1:0] od_q, od_d;
  logic [CW-1:0] och_q, och_d;

  logic          soft_rst;
  logic          grant_rdy;
  logic          xfer;
  logic          rel;

  logic [CW-1:0] rr_win;
  logic [CW:0]   rr_idx;
  logic          rr_found;
  logic [CW-1:0] fp_win;
  logic          fp_found;

  assign soft_rst = rst_i | clear_i;

  // Round-robin winner: first valid channel at or after rr_q, wrapping.
  always_comb begin
    rr_win   = rr_q;
    rr_found = 1'b0;
    rr_idx   = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      rr_idx = {1'b0, rr_q} + (CW+1)'(k);
      if (rr_idx >= N_CH_W) begin
        rr_idx = rr_idx - N_CH_W;
      end
      if (!rr_found && in_valid_i[rr_idx[CW-1:0]]) begin
        rr_found = 1'b1;
        rr_win   = rr_idx[CW-1:0];
      end
    end
  end

  // Fixed-priority winner: lowest valid index.
  always_comb begin
    fp_win   = '0;
    fp_found = 1'b0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (!fp_found && in_valid_i[k]) begin
        fp_found = 1'b1;
        fp_win   = CW'(k);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_d       = rr_q;
    beat_d     = beat_q;
    ov_d       = ov_q;
    od_d       = od_q;
    och_d      = och_q;
    in_ready_o = '0;
    grant_rdy  = 1'b0;
    xfer       = 1'b0;
    rel        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (enable_i && (|in_valid_i)) begin
          grant_d = mode_i ? fp_win : rr_win;
          beat_d  = '0;
          state_d = LOCK;
        end
      end
      LOCK: begin
        // Reset/clear dominate: a beat offered in that cycle would be
        // discarded by the clear, so it is not acknowledged upstream.
        grant_rdy           = enable_i & (~ov_q | out_ready_i) & ~soft_rst;
        in_ready_o[grant_q] = grant_rdy;
        xfer                = in_valid_i[grant_q] & grant_rdy;
        if (xfer) begin
          beat_d = beat_q + BW'(1);
        end
        rel = (xfer && (beat_q == LAST_BEAT)) ||
              (!in_valid_i[grant_q] && enable_i);
        if (rel) begin
          state_d = IDLE;
          beat_d  = '0;
          rr_d    = (grant_q == LAST_CH) ? '0 : grant_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Output register: a new beat overrides a drain in the same cycle,
    // which keeps one beat per cycle flowing under out_ready_i=1.
    if (xfer) begin
      ov_d  = 1'b1;
      od_d  = in_data_i[grant_q*DW +: DW];
      och_d = grant_q;
    end else if (out_ready_i) begin
      ov_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (soft_rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      beat_q  <= '0;
      ov_q    <= 1'b0;
      od_q    <= '0;
      och_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      beat_q  <= beat_d;
      ov_q    <= ov_d;
      od_q    <= od_d;
      och_q   <= och_d;
    end
  end

  assign out_valid_o = ov_q;
  assign out_data_o  = od_q;
  assign out_ch_o    = och_q;
  assign busy_o      = (state_q == LOCK);

endmodule

// File: tb/tb_nvdla_stream_arbiter.sv
// Testbench for nvdla_stream_arbiter (N_CH=3, DW=32, MAX_BURST=4).
// A behavioural model predicts all outputs; a compare process checks them
// on every falling edge. Directed scenarios add literal expectations.
module tb_nvdla_stream_arbiter;

  localparam int N  = 3;
  localparam int DW = 32;
  localparam int MB = 4;
  localparam int CW = $clog2(N);

  logic            clk = 1'b0;
  logic            rst, en, clr, mode, oready;
  logic [N-1:0]    vld, rdy;
  logic [N*DW-1:0] data;
  logic            ov, busy;
  logic [DW-1:0]   od;
  logic [CW-1:0]   och;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // model state
  bit            m_lock, m_ov, m_take;
  int            m_grant, m_beats, m_rr, m_och;
  logic [DW-1:0] m_od;
  logic [N-1:0]  exp_rdy;

  // directed-scenario scratch
  int rr_v [21] = '{0,0,1,1,1,1,0,1,1,1,1,0,1,1,1,1,0,1,1,1,1};
  int rr_c [21] = '{0,0,0,0,0,0,0,1,1,1,1,1,2,2,2,2,2,0,0,0,0};
  int er_b [7]  = '{0,1,1,1,0,1,1};
  int s_v [32];
  int s_c [32];
  int s_b [32];
  int chq [$];
  logic [DW-1:0] consumed [$];
  logic [DW-1:0] s_d [32];

  always #5 clk = ~clk;

  nvdla_stream_arbiter #(
    .N_CH      (N),
    .DW        (DW),
    .MAX_BURST (MB)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .enable_i    (en),
    .clear_i     (clr),
    .mode_i      (mode),
    .in_valid_i  (vld),
    .in_data_i   (data),
    .in_ready_o  (rdy),
    .out_valid_o (ov),
    .out_data_o  (od),
    .out_ch_o    (och),
    .out_ready_i (oready),
    .busy_o      (busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v, input int rr, input logic fixed);
    for (int k = 0; k < N; k++) begin
      int c;
      c = fixed ? k : (rr + k) % N;
      if (v[c]) return c;
    end
    return 0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
  endtask

  task automatic set_chan_data(input logic [DW-1:0] base);
    for (int c = 0; c < N; c++) data[c*DW +: DW] = base + DW'(c * 32'h100);
  endtask

  // Behavioural model, advanced on each rising edge from the inputs
  // that were applied during the preceding cycle.
  initial forever begin
    @(posedge clk);
    if (rst || clr) begin
      m_lock = 0; m_grant = 0; m_beats = 0; m_rr = 0;
      m_ov = 0; m_od = '0; m_och = 0;
    end else if (!m_lock) begin
      if (oready) m_ov = 0;
      if (en && vld != '0) begin
        m_grant = pick(vld, m_rr, mode);
        m_beats = 0;
        m_lock  = 1;
      end
    end else begin
      m_take = vld[m_grant] && en && (!m_ov || oready);
      if (m_take) begin
        m_od  = data[m_grant*DW +: DW];
        m_och = m_grant;
        m_ov  = 1;
        m_beats++;
      end else if (oready) begin
        m_ov = 0;
      end
      if ((m_take && m_beats == MB) || (!vld[m_grant] && en)) begin
        m_lock = 0;
        m_rr   = (m_grant + 1) % N;
      end
    end
  end

  // Compare process
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      exp_rdy = '0;
      if (m_lock && en && !rst && !clr && (!m_ov || oready)) exp_rdy[m_grant] = 1'b1;
      chk("out_valid", 64'(ov), 64'(m_ov));
      chk("out_data", 64'(od), 64'(m_od));
      chk("out_ch", 64'(och), 64'(m_och));
      chk("busy", 64'(busy), 64'(m_lock));
      chk("in_ready", 64'(rdy), 64'(exp_rdy));
    end
  end

  initial begin
    int first, n1, n2, hs;
    logic [DW-1:0] cnt;

    // ---- reset with all inputs driven, then round-robin continuous ----
    rst = 1'b1; clr = 1'b0; en = 1'b1; mode = 1'b0; oready = 1'b1;
    vld = '1; data = '0; set_chan_data(32'h10);
    step();
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_valid", 64'(ov), 64'd0);
    chk("rst_ready", 64'(rdy), 64'd0);
    step();
    rst = 1'b0;
    for (int n = 0; n < 21; n++) begin
      @(negedge clk);
      s_v[n] = int'(ov); s_c[n] = int'(och);
      if (n == 0) begin
        chk("post_rst_valid", 64'(ov), 64'd0);
        chk("post_rst_data", 64'(od), 64'd0);
        chk("post_rst_ch", 64'(och), 64'd0);
        chk("post_rst_busy", 64'(busy), 64'd0);
        chk("post_rst_ready", 64'(rdy), 64'd0);
      end
      step();
    end
    first = -1;
    for (int n = 20; n >= 0; n--) if (s_v[n] == 1) first = n;
    chk("rr_first_valid", 64'(first), 64'd2);
    for (int n = 0; n < 21; n++) begin
      chk("rr_valid_seq", 64'(s_v[n]), 64'(rr_v[n]));
      chk("rr_ch_seq", 64'(s_c[n]), 64'(rr_c[n]));
    end

    // ---- fixed priority: 1 then 0, channel 2 starves ----
    en = 1'b1; mode = 1'b1; oready = 1'b1; vld = 3'b000;
    do_reset();
    vld = 3'b110; set_chan_data(32'h20);
    chq.delete();
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (ov) chq.push_back(int'(och));
      step();
      if (n == 3) vld = 3'b111;
    end
    n1 = 0; n2 = 0;
    foreach (chq[i]) begin
      if (chq[i] == 1) n1++;
      if (chq[i] == 2) n2++;
    end
    chk("fp_first_ch", 64'(chq[0]), 64'd1);
    chk("fp_second_grant", 64'(chq[4]), 64'd0);
    chk("fp_ch1_beats", 64'(n1), 64'd4);
    chk("fp_ch2_starved", 64'(n2), 64'd0);

    // ---- backpressure: out_ready 1,1,1,0,0,1,... ----
    mode = 1'b0; vld = '0;
    do_reset();
    cnt = 32'hA0; data = '0; data[DW-1:0] = cnt; vld = 3'b001; oready = 1'b1;
    consumed.delete();
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      hs = int'(rdy[0] && vld[0]);
      if (ov && oready) consumed.push_back(od);
      s_d[n] = od;
      if (n == 3) chk("bp_ready_follows", 64'(rdy[0]), 64'd0);
      step();
      if (hs != 0) cnt = cnt + 1;
      data[DW-1:0] = cnt;
      vld[0] = (cnt < 32'hA3);
      oready = !(n == 2 || n == 3);
    end
    chk("bp_hold_n3", 64'(s_d[3]), 64'hA1);
    chk("bp_hold_n4", 64'(s_d[4]), 64'hA1);
    chk("bp_count", 64'(consumed.size()), 64'd3);
    for (int i = 0; i < 3; i++) chk("bp_seq", 64'(consumed[i]), 64'(32'hA0 + i));

    // ---- early release: channel 0 drops after 2 beats ----
    vld = '0;
    do_reset();
    vld = 3'b011; set_chan_data(32'h30); oready = 1'b1; hs = 0;
    for (int n = 0; n < 9; n++) begin
      @(negedge clk);
      s_b[n] = int'(busy); s_v[n] = int'(ov); s_c[n] = int'(och);
      if (rdy[0] && vld[0]) hs++;
      step();
      vld[0] = (hs < 2);
    end
    for (int n = 0; n < 7; n++) chk("er_busy_seq", 64'(s_b[n]), 64'(er_b[n]));
    n1 = 0;
    for (int n = 0; n < 9; n++) if (s_v[n] == 1 && s_c[n] == 0) n1++;
    chk("er_ch0_beats", 64'(n1), 64'd2);
    chk("er_next_ch", 64'(s_c[6]), 64'd1);
    chk("er_next_valid", 64'(s_v[6]), 64'd1);

    // ---- clear during third beat of channel 1 burst ----
    vld = '0;
    do_reset();
    vld = '1; set_chan_data(32'h40); oready = 1'b1;
    for (int n = 0; n < 13; n++) begin
      @(negedge clk);
      s_b[n] = int'(busy); s_v[n] = int'(ov); s_c[n] = int'(och);
      step();
      clr = (n == 7);
    end
    chk("clr_in_ch1_burst", 64'(s_c[8]), 64'd1);
    chk("clr_valid", 64'(s_v[9]), 64'd0);
    chk("clr_busy", 64'(s_b[9]), 64'd0);
    chk("clr_rearb_busy", 64'(s_b[10]), 64'd1);
    chk("clr_rearb_ch", 64'(s_c[11]), 64'd0);
    chk("clr_rearb_valid", 64'(s_v[11]), 64'd1);

    // ---- randomized traffic against the model ----
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      vld    = N'($urandom_range(0, (1 << N) - 1));
      for (int c = 0; c < N; c++) data[c*DW +: DW] = $urandom();
      en     = ($urandom_range(0, 7) != 0);
      mode   = ($urandom_range(0, 3) == 0);
      oready = ($urandom_range(0, 2) != 0);
      clr    = ($urandom_range(0, 63) == 0);
      rst    = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 1'b0; clr = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nvdla_stream_arbiter.md
# nvdla_stream_arbiter

- Parametrised N-channel arbiter merging several HWPE data streams onto one output stream.
- Successor to the single-channel DBB/CSB stream plumbing between `nvdla_engine` and `nvdla_streamer`.
- Supports runtime-selectable round-robin or fixed-priority arbitration, bounded burst locking, and a registered output stage.
- Sits between the per-source streams and the shared streamer sink port.

## Interface
Parameters:
- `N_CH`, 3: number of input channels; must be ≥ 2.
- `DW`, 32: data width of every stream.
- `MAX_BURST`, 16: maximum beats per grant; must be ≥ 1.

Ports:
- `clk_i` in 1: single clock; all logic on the rising edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `enable_i` in 1: when 0, no new grant is issued and the granted input is frozen.
- `clear_i` in 1: synchronous soft clear; same effect as `rst_i`.
- `mode_i` in 1: 0 = round-robin, 1 = fixed priority (lowest index wins).
- `in_valid_i` in N_CH: per-channel valid.
- `in_data_i` in N_CH×DW: per-channel data.
- `in_ready_o` out N_CH: per-channel ready.
- `out_valid_o` out 1: output valid (registered).
- `out_data_o` out DW: output data (registered).
- `out_ch_o` out $clog2(N_CH): source channel of the current output beat.
- `out_ready_i` in 1: downstream ready.
- `busy_o` out 1: FSM is in LOCK.

## Operation
- **Reset / clear:** reset or `clear_i` sets FSM=IDLE, grant=0, rr_ptr=0, beat_cnt=0, `out_valid_o`=0, `out_data_o`=0, `out_ch_o`=0, `in_ready_o`=0. `rst_i` and `clear_i` take priority over all other inputs.
- **FSM states:** IDLE and LOCK.
- **IDLE:**
  - If `enable_i`=1 and any `in_valid_i` bit is set, select a winner, register it as grant, set beat_cnt=0 and go to LOCK.
  - Round-robin search starts at rr_ptr and wraps modulo N_CH.
  - Fixed priority picks the lowest set index.
  - `mode_i` is sampled only in IDLE; a change during LOCK has no effect until the next arbitration.
- **LOCK:**
  - `in_ready_o[grant]` = `enable_i` & (!`out_valid_o` | `out_ready_i`). All other `in_ready_o` bits are 0.
  - **Transfer:** a beat moves when `in_valid_i[grant]` & `in_ready_o[grant]`. It loads `out_data_o`←`in_data_i[grant]`, `out_ch_o`←grant, `out_valid_o`←1, and increments beat_cnt.
  - **Release to IDLE** on either condition:
    - (a) a transfer occurs with beat_cnt = MAX_BURST-1;
    - (b) `in_valid_i[grant]`=0 and `enable_i`=1.
  - On release, rr_ptr ← (grant+1) mod N_CH; this also wraps from N_CH-1 to 0. rr_ptr is updated in fixed-priority mode too.
  - If `enable_i`=0: FSM, grant, and beat_cnt hold; no release on (b).
- **Output stage:**
  - `out_valid_o` clears on `out_ready_i`=1 when no new transfer occurs in that cycle.
  - It stays 1 when a transfer and a drain coincide (full throughput).
  - While `out_ready_i`=0, `out_data_o` and `out_ch_o` hold stable.
  - The output stage drains regardless of `enable_i`.
- **beat_cnt:** width $clog2(MAX_BURST+1); it never exceeds MAX_BURST-1 while in LOCK.
- **MAX_BURST=1:** every beat releases the grant, giving one beat per grant with strict alternation under round-robin.

## Timing
- **First-beat latency:** valid seen in IDLE at cycle 0 → grant registered, LOCK at cycle 1 with `in_ready_o` high → `out_valid_o`=1 at cycle 2.
- **Throughput:** 1 beat/cycle within a burst when `out_ready_i` is held 1.
- **Burst gap:** one IDLE bubble cycle between consecutive bursts (re-arbitration).
- **Backpressure:** `in_ready_o[grant]` follows `out_ready_i` combinationally in the same cycle. There is no combinational path from `in_valid_i` to `in_ready_o`.
- **Valid drop:** a drop of `in_valid_i[grant]` in LOCK releases the grant at the next edge; no beat is lost.

## Test plan
- **Reset values:** assert `rst_i` for 2 cycles with all inputs driven → all outputs 0 and `busy_o`=0 the cycle after reset.
- **Round-robin, continuous valids:** N_CH=3, MAX_BURST=4, all channels continuously valid, `out_ready_i`=1 → bursts of 4 in channel order 0,1,2,0. `out_ch_o` sequence 0000 1111 2222 0000 with a 1-cycle bubble between bursts. First `out_valid_o` at cycle 2.
- **Fixed priority:** `mode_i`=1, channels 1 and 2 valid, channel 0 asserted after the first burst → grants go 1, then 0, and channel 2 starves while 0 or 1 is valid.
- **Backpressure:** toggle `out_ready_i` 1,0,0,1 during a burst with data 0xA0.. → `out_data_o` is held stable while ready=0. Output sequence is 0xA0,0xA1,0xA2 with no loss or duplication.
- **Early release:** channel 0 drops valid after 2 of MAX_BURST=16 beats while channel 1 is valid → release after 2 beats, then channel 1 is granted following one IDLE cycle.
- **Clear mid-burst:** `clear_i` pulsed during the third beat → the next cycle has `out_valid_o`=0, `busy_o`=0, rr_ptr=0. Re-arbitration from channel 0 occurs the following cycle.
